// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel programmable timer: count modes,
// control-word bit positions and a decoder for the control word.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_STOP    = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_RELOAD  = 2'b10,
    MODE_SQUARE  = 2'b11
  } mode_e;

  localparam int unsigned CTRL_MODE_LSB = 0;
  localparam int unsigned CTRL_MODE_W   = 2;
  localparam int unsigned CTRL_IRQEN    = 2;
  localparam int unsigned CTRL_CLRPEND  = 3;
  localparam int unsigned CTRL_W        = 4;

  typedef struct packed {
    logic  clr_pend;
    logic  irq_en;
    mode_e mode;
  } ctrl_word_t;

  // Bits above the control field are ignored by the caller.
  function automatic ctrl_word_t decode_ctrl(input logic [CTRL_W-1:0] bits);
    ctrl_word_t d;
    d.mode     = mode_e'(bits[CTRL_MODE_LSB +: CTRL_MODE_W]);
    d.irq_en   = bits[CTRL_IRQEN];
    d.clr_pend = bits[CTRL_CLRPEND];
    return d;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: count-clock synchroniser and edge detect, down counter
// with reload, mode/irq-enable control, output flag and interrupt pending.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cnt_clk,
  input  logic         wr_en,
  input  logic         wr_ctrl,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] count,
  output logic         flag,
  output logic         irq_req_c
);

  logic       sync1;
  logic       sync2;
  logic       edge_q;
  logic       armed;
  mode_e      mode;
  logic       irq_en;
  logic       pending;
  logic [W-1:0] reload;

  logic       tick;
  logic       terminal;
  logic       wr_reload;
  logic       wr_control;
  ctrl_word_t ctrl_c;

  assign ctrl_c     = decode_ctrl(wr_data[CTRL_W-1:0]);
  assign wr_reload  = wr_en && !wr_ctrl;
  assign wr_control = wr_en && wr_ctrl;

  // A tick needs a low level seen after reset, so a high cnt_clk at release is not an edge.
  assign tick = sync2 && !edge_q && armed && !wr_en &&
                (mode != MODE_STOP) && (count != '0);
  assign terminal = tick && (count == W'(1));

  assign irq_req_c = pending && irq_en;

  // Two-flop synchroniser and rising-edge detector for the count clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      edge_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync1  <= cnt_clk;
      sync2  <= sync1;
      edge_q <= sync2;
      armed  <= armed || !sync2;
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= '0;
      mode   <= MODE_STOP;
      irq_en <= 1'b0;
    end else begin
      if (wr_reload) begin
        reload <= wr_data;
      end
      if (wr_control) begin
        mode   <= ctrl_c.mode;
        irq_en <= ctrl_c.irq_en;
      end
    end
  end

  // Down counter; a write to this channel always beats a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_reload) begin
      count <= wr_data;
    end else if (terminal) begin
      count <= (mode == MODE_ONESHOT) ? '0 : reload;
    end else if (tick) begin
      count <= count - W'(1);
    end
  end

  // Output flag: held in one-shot, single-cycle pulse in auto-reload, toggle in square-wave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
    end else if (wr_reload) begin
      flag <= 1'b0;
    end else if (terminal) begin
      case (mode)
        MODE_ONESHOT: flag <= 1'b1;
        MODE_RELOAD:  flag <= 1'b1;
        MODE_SQUARE:  flag <= !flag;
        default:      flag <= flag;
      endcase
    end else if (mode == MODE_RELOAD) begin
      flag <= 1'b0;
    end
  end

  // Interrupt pending: a terminal event takes priority over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (terminal) begin
      pending <= 1'b1;
    end else if (wr_control && ctrl_c.clr_pend) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_counter_n.sv
// Parametrised multi-channel programmable timer: CH independent down counters
// written over MIO_BUS, with a shared maskable interrupt.
module timer_counter_n
  import timer_pkg::*;
#(
  parameter  int unsigned CH = 4,
  parameter  int unsigned W  = 32,
  localparam int unsigned CW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic [CH-1:0] cnt_clk,
  input  logic          counter_we,
  input  logic          wr_ctrl,
  input  logic [CW-1:0] counter_ch,
  input  logic [W-1:0]  counter_val,
  output logic [W-1:0]  counter_out,
  output logic [CH-1:0] counter_flag,
  output logic          irq
);

  logic [CH-1:0] wr_en;
  logic [CH-1:0] irq_req_c;
  logic [W-1:0]  count_q [CH];

  for (genvar g = 0; g < CH; g++) begin : g_ch
    // Out-of-range channel numbers match no decode and are dropped
    assign wr_en[g] = counter_we && (counter_ch == CW'(g));

    timer_channel #(
      .W(W)
    ) u_channel (
      .clk       (clk),
      .rst_n     (RSTN),
      .cnt_clk   (cnt_clk[g]),
      .wr_en     (wr_en[g]),
      .wr_ctrl   (wr_ctrl),
      .wr_data   (counter_val),
      .count     (count_q[g]),
      .flag      (counter_flag[g]),
      .irq_req_c (irq_req_c[g])
    );
  end

  // Read-back mux; unmatched channel numbers read as zero
  always_comb begin
    counter_out = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (counter_ch == CW'(i)) begin
        counter_out = count_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      irq <= 1'b0;
    end else begin
      irq <= |irq_req_c;
    end
  end

endmodule

// File: tb/tb_timer_counter_n.sv
// Directed bench for timer_counter_n: a 4x32 instance driven from a vector
// table plus hand sequences, and a 3x8 instance for width wrap and decode.
module tb_timer_counter_n;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  cc_a;
  logic        we_a, ctrl_a;
  logic [1:0]  ch_a;
  logic [31:0] val_a, out_a;
  logic [3:0]  flag_a;
  logic        irq_a;

  logic [2:0]  cc_b;
  logic        we_b, ctrl_b;
  logic [1:0]  ch_b;
  logic [7:0]  val_b, out_b;
  logic [2:0]  flag_b;
  logic        irq_b;

  timer_counter_n #(.CH(4), .W(32)) dut_a (
    .clk(clk), .RSTN(rst_n), .cnt_clk(cc_a), .counter_we(we_a), .wr_ctrl(ctrl_a),
    .counter_ch(ch_a), .counter_val(val_a), .counter_out(out_a),
    .counter_flag(flag_a), .irq(irq_a)
  );

  timer_counter_n #(.CH(3), .W(8)) dut_b (
    .clk(clk), .RSTN(rst_n), .cnt_clk(cc_b), .counter_we(we_b), .wr_ctrl(ctrl_b),
    .counter_ch(ch_b), .counter_val(val_b), .counter_out(out_b),
    .counter_flag(flag_b), .irq(irq_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_a(input logic [1:0] ch, input logic ctrl, input logic [31:0] v);
    @(negedge clk);
    we_a = 1'b1; ctrl_a = ctrl; ch_a = ch; val_a = v;
    @(negedge clk);
    we_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_b(input logic [1:0] ch, input logic ctrl, input logic [7:0] v);
    @(negedge clk);
    we_b = 1'b1; ctrl_b = ctrl; ch_b = ch; val_b = v;
    @(negedge clk);
    we_b = 1'b0;
    @(negedge clk);
  endtask

  // pulse samples the flags right after the edge that applies the tick
  task automatic tick_a(input logic [3:0] mask, output logic [3:0] pulse);
    @(negedge clk);
    cc_a = cc_a | mask;
    repeat (3) @(negedge clk);
    pulse = flag_a;
    cc_a = cc_a & ~mask;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick_b(input logic [2:0] mask, output logic [2:0] pulse);
    @(negedge clk);
    cc_b = cc_b | mask;
    repeat (3) @(negedge clk);
    pulse = flag_b;
    cc_b = cc_b & ~mask;
    repeat (3) @(negedge clk);
  endtask

  typedef enum logic [1:0] {OP_RELOAD, OP_CTRL, OP_TICK} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  ch;
    logic [31:0] val;
    logic [31:0] exp_out;
    logic [3:0]  exp_flag;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pa;
    logic [2:0] pb;
    logic       prev_flag;
    int         toggles;

    cc_a = '0; we_a = 1'b0; ctrl_a = 1'b0; ch_a = '0; val_a = '0;
    cc_b = '0; we_b = 1'b0; ctrl_b = 1'b0; ch_b = '0; val_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst out", out_a, 32'h0);
    chk("rst flag", 32'(flag_a), 32'h0);
    chk("rst irq", 32'(irq_a), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // op, ch, val/mask, expected counter_out, expected flags, expected irq
    vecs.push_back('{OP_RELOAD, 2'd0, 32'd3,  32'd3, 4'b0000, 1'b0});
    vecs.push_back('{OP_CTRL,   2'd0, 32'd1,  32'd3, 4'b0000, 1'b0});
    vecs.push_back('{OP_TICK,   2'd0, 32'h1,  32'd2, 4'b0000, 1'b0});
    vecs.push_back('{OP_TICK,   2'd0, 32'h1,  32'd1, 4'b0000, 1'b0});
    vecs.push_back('{OP_TICK,   2'd0, 32'h1,  32'd0, 4'b0001, 1'b0});
    vecs.push_back('{OP_TICK,   2'd0, 32'h1,  32'd0, 4'b0001, 1'b0});
    vecs.push_back('{OP_RELOAD, 2'd1, 32'd2,  32'd2, 4'b0001, 1'b0});
    vecs.push_back('{OP_CTRL,   2'd1, 32'd6,  32'd2, 4'b0001, 1'b0});
    vecs.push_back('{OP_TICK,   2'd1, 32'h2,  32'd1, 4'b0001, 1'b0});
    vecs.push_back('{OP_TICK,   2'd1, 32'h2,  32'd2, 4'b0011, 1'b1});
    vecs.push_back('{OP_TICK,   2'd1, 32'h2,  32'd1, 4'b0001, 1'b1});
    vecs.push_back('{OP_CTRL,   2'd1, 32'd14, 32'd1, 4'b0001, 1'b0});
    vecs.push_back('{OP_TICK,   2'd1, 32'h2,  32'd2, 4'b0011, 1'b1});
    vecs.push_back('{OP_RELOAD, 2'd2, 32'd4,  32'd4, 4'b0001, 1'b1});
    vecs.push_back('{OP_CTRL,   2'd1, 32'd10, 32'd2, 4'b0001, 1'b0});
    vecs.push_back('{OP_CTRL,   2'd2, 32'd3,  32'd4, 4'b0001, 1'b0});

    foreach (vecs[k]) begin
      logic [3:0] f;
      case (vecs[k].op)
        OP_RELOAD: wr_a(vecs[k].ch, 1'b0, vecs[k].val);
        OP_CTRL:   wr_a(vecs[k].ch, 1'b1, vecs[k].val);
        default: begin
          ch_a = vecs[k].ch;
          tick_a(vecs[k].val[3:0], pa);
        end
      endcase
      f = (vecs[k].op == OP_TICK) ? pa : flag_a;
      chk($sformatf("vec%0d out", k), out_a, vecs[k].exp_out);
      chk($sformatf("vec%0d flag", k), 32'(f), 32'(vecs[k].exp_flag));
      chk($sformatf("vec%0d irq", k), 32'(irq_a), 32'(vecs[k].exp_irq));
    end

    // Square wave on ch2, reload 4: flag toggles every 4 ticks
    ch_a = 2'd2;
    prev_flag = flag_a[2];
    toggles = 0;
    for (int k = 1; k <= 16; k++) begin
      tick_a(4'b0100, pa);
      if (flag_a[2] != prev_flag) toggles++;
      prev_flag = flag_a[2];
      chk($sformatf("sq%0d out", k), out_a, (k % 4 == 0) ? 32'd4 : 32'(4 - (k % 4)));
      chk($sformatf("sq%0d flag", k), 32'(flag_a[2]), 32'((k / 4) % 2));
    end
    chk("sq toggles", 32'(toggles), 32'd4);

    // Reload write to ch3 on the same edge as its tick: write wins
    wr_a(2'd3, 1'b0, 32'd10);
    wr_a(2'd3, 1'b1, 32'd2);
    @(negedge clk);
    cc_a[3] = 1'b1;
    repeat (2) @(negedge clk);
    we_a = 1'b1; ctrl_a = 1'b0; ch_a = 2'd3; val_a = 32'd7;
    @(negedge clk);
    we_a = 1'b0;
    chk("coll wr out", out_a, 32'd7);
    cc_a[3] = 1'b0;
    repeat (4) @(negedge clk);
    chk("coll wr hold", out_a, 32'd7);

    // Terminal event on ch1 on the same edge as a clear-pending write to ch0
    wr_a(2'd0, 1'b1, 32'd5);
    chk("ch0 irq en", 32'(irq_a), 32'd1);
    wr_a(2'd1, 1'b1, 32'd6);
    ch_a = 2'd1;
    tick_a(4'b0010, pa);
    chk("ch1 pre", out_a, 32'd1);
    @(negedge clk);
    cc_a[1] = 1'b1;
    repeat (2) @(negedge clk);
    we_a = 1'b1; ctrl_a = 1'b1; ch_a = 2'd0; val_a = 32'd13;
    @(negedge clk);
    we_a = 1'b0;
    chk("coll term flag", 32'(flag_a[1]), 32'd1);
    chk("coll irq n", 32'(irq_a), 32'd1);
    @(negedge clk);
    chk("coll irq n1", 32'(irq_a), 32'd1);
    cc_a[1] = 1'b0;
    @(negedge clk);
    chk("coll irq n2", 32'(irq_a), 32'd1);

    // Clear ch1: irq stays through the write edge, drops one edge later
    @(negedge clk);
    we_a = 1'b1; ctrl_a = 1'b1; ch_a = 2'd1; val_a = 32'd14;
    @(negedge clk);
    we_a = 1'b0;
    chk("clr irq n", 32'(irq_a), 32'd1);
    @(negedge clk);
    chk("clr irq n1", 32'(irq_a), 32'd0);

    // Asynchronous reset mid-count with the count clock rising
    wr_a(2'd2, 1'b1, 32'd7);
    chk("pre rst irq", 32'(irq_a), 32'd1);
    wr_a(2'd0, 1'b0, 32'd100);
    wr_a(2'd0, 1'b1, 32'd2);
    tick_a(4'b0001, pa);
    chk("pre rst out", out_a, 32'd99);
    @(negedge clk);
    cc_a[0] = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out", out_a, 32'h0);
    chk("async rst flag", 32'(flag_a), 32'h0);
    chk("async rst irq", 32'(irq_a), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst out", out_a, 32'h0);
    wr_a(2'd0, 1'b0, 32'd5);
    wr_a(2'd0, 1'b1, 32'd2);
    repeat (4) @(negedge clk);
    chk("no release tick", out_a, 32'd5);
    cc_a[0] = 1'b0;
    repeat (3) @(negedge clk);
    tick_a(4'b0001, pa);
    chk("first tick after rst", out_a, 32'd4);

    // Narrow instance: 8-bit wrap from FF and channel decode
    wr_b(2'd0, 1'b0, 8'hFF);
    wr_b(2'd0, 1'b1, 8'd2);
    chk("b load", 32'(out_b), 32'hFF);
    tick_b(3'b001, pb);
    chk("b first", 32'(out_b), 32'hFE);
    for (int k = 0; k < 253; k++) tick_b(3'b001, pb);
    chk("b at one", 32'(out_b), 32'h01);
    tick_b(3'b001, pb);
    chk("b reload", 32'(out_b), 32'hFF);
    chk("b pulse", 32'(pb), 32'b001);
    chk("b flag after", 32'(flag_b), 32'b000);
    wr_b(2'd3, 1'b0, 8'h55);
    chk("b oor out", 32'(out_b), 32'h0);
    ch_b = 2'd0;
    @(negedge clk);
    chk("b ch0 kept", 32'(out_b), 32'hFF);
    wr_b(2'd2, 1'b0, 8'h42);
    chk("b ch2", 32'(out_b), 32'h42);
    chk("b irq", 32'(irq_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
